// File: rtl/arbitro_bus.sv
// -----------------------------------------------------------------------------
// arbitro_bus
// Two-master bus arbiter. Master 0 is the CPU and master 1 is the UART message
// engine. It serialises single read or write transactions onto one shared
// slave bus. Simultaneous requests are resolved round robin.
//
// Parameters
//   READ_LAT      cycles from read address presentation to valid bus_rdata_i
//                 (legal range 1..7)
//
// Ports
//   clk_i         clock; all state changes on its rising edge
//   rst_n_i       asynchronous active-low reset
//   req_i[1:0]    per-master transaction request
//   we_i[1:0]     per-master write flag (1 = write, 0 = read)
//   addr0/1_i     per-master byte address
//   wdata0/1_i    per-master write data
//   ack_o[1:0]    one-cycle completion pulse to the served master
//   rdata_o       data of the most recent completed read
//   bus_addr_o    address to the decoder and slaves (0 while idle)
//   bus_wdata_o   write data to the slaves (0 while idle)
//   bus_we_o      write strobe, high for the single ACCESS cycle of a write
//   bus_rdata_i   read data from the slave mux
//   busy_o        transaction in flight
//   owner_o       current or last granted master
// -----------------------------------------------------------------------------
module arbitro_bus #(
    parameter int READ_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic [1:0]  ack_o,
    output logic [31:0] rdata_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic        bus_we_o,
    input  logic [31:0] bus_rdata_i,
    output logic        busy_o,
    output logic        owner_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(READ_LAT - 1);

    state_t      state_q;
    logic        owner_q;
    logic        last_q;      // master that received the most recent ack
    logic [2:0]  cnt_q;
    logic [1:0]  ack_q;
    logic [31:0] rdata_q;

    logic        grant_d;     // master that wins if a request is accepted now
    logic        owner_we;

    // A lone request wins outright; under contention the master that was not
    // served last wins, so back-to-back contention alternates.
    always_comb begin
        grant_d = req_i[1];
        if (req_i == 2'b11) begin
            grant_d = ~last_q;
        end
    end

    assign owner_we = we_i[owner_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;  // master 0 wins the first contention
            cnt_q   <= 3'd0;
            ack_q   <= 2'b00;
            rdata_q <= 32'd0;
        end else begin
            ack_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (req_i != 2'b00) begin
                        owner_q <= grant_d;
                        state_q <= ACCESS;
                        // A write completes in its ACCESS cycle, so its ack
                        // is launched on the grant edge.
                        if (we_i[grant_d]) begin
                            ack_q  <= {grant_d, ~grant_d};
                            last_q <= grant_d;
                        end
                    end
                end
                ACCESS: begin
                    if (owner_we) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (cnt_q == 3'd0) begin
                        rdata_q <= bus_rdata_i;
                        ack_q   <= {owner_q, ~owner_q};
                        last_q  <= owner_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus side follows the owner's live inputs while a transaction is open.
    assign bus_addr_o  = (state_q == IDLE) ? 32'd0 : (owner_q ? addr1_i : addr0_i);
    assign bus_wdata_o = (state_q == IDLE) ? 32'd0 : (owner_q ? wdata1_i : wdata0_i);
    assign bus_we_o    = (state_q == ACCESS) && owner_we;

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign busy_o  = (state_q != IDLE);
    assign owner_o = owner_q;

endmodule

// File: tb/tb_arbitro_bus.sv
// -----------------------------------------------------------------------------
// tb_arbitro_bus
// Drives two arbiter instances: instance 0 with READ_LAT = 1 and instance 1
// with READ_LAT = 3. The expected results come from a transaction-level model.
// For each transaction the model gives the winner, the ack cycle, the bus
// contents and the returned read data.
// -----------------------------------------------------------------------------
module tb_arbitro_bus;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    [2];
    logic [1:0]  req      [2];
    logic [1:0]  we       [2];
    logic [31:0] addr0    [2];
    logic [31:0] addr1    [2];
    logic [31:0] wdata0   [2];
    logic [31:0] wdata1   [2];
    logic [1:0]  ack      [2];
    logic [31:0] rdata    [2];
    logic [31:0] bus_addr [2];
    logic [31:0] bus_wdata[2];
    logic        bus_we   [2];
    logic [31:0] bus_rdata[2];
    logic        busy     [2];
    logic        owner    [2];

    int total = 0;
    int bad   = 0;

    // Model state per instance
    int          last_served[2];
    logic [31:0] last_rd    [2];

    // Slave contents seen through the bus address
    function automatic logic [31:0] slave_fn(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hDEADBEEF;
        if (a == 32'h0000_2000) return 32'h0000_000F;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [1:0] onehot(input int m);
        return (m == 1) ? 2'b10 : 2'b01;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        assign bus_rdata[gi] = slave_fn(bus_addr[gi]);
        arbitro_bus #(.READ_LAT((gi == 0) ? 1 : 3)) u_dut (
            .clk_i      (clk),
            .rst_n_i    (rst_n[gi]),
            .req_i      (req[gi]),
            .we_i       (we[gi]),
            .addr0_i    (addr0[gi]),
            .addr1_i    (addr1[gi]),
            .wdata0_i   (wdata0[gi]),
            .wdata1_i   (wdata1[gi]),
            .ack_o      (ack[gi]),
            .rdata_o    (rdata[gi]),
            .bus_addr_o (bus_addr[gi]),
            .bus_wdata_o(bus_wdata[gi]),
            .bus_we_o   (bus_we[gi]),
            .bus_rdata_i(bus_rdata[gi]),
            .busy_o     (busy[gi]),
            .owner_o    (owner[gi])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, " ack"},   32'(ack[d]),  32'd0);
        chk({tag, " busy"},  32'(busy[d]), 32'd0);
        chk({tag, " baddr"}, bus_addr[d],  32'd0);
        chk({tag, " bwdat"}, bus_wdata[d], 32'd0);
        chk({tag, " bwe"},   32'(bus_we[d]), 32'd0);
    endtask

    // One transaction from an idle arbiter. With 'both' set the other master
    // also requests at the same time. The model picks the winner, and the
    // loser withdraws once the grant has been made.
    task automatic do_txn(input int d, input int m_in, input bit both, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd, input bit drop);
        int m, o, n_cyc, L;
        logic [31:0] exp_rd;
        L = lat_of(d);
        m = both ? (1 - last_served[d]) : m_in;
        o = 1 - m;
        we[d][m] = wr;
        if (m == 0) begin addr0[d] = a; wdata0[d] = wd; end
        else        begin addr1[d] = a; wdata1[d] = wd; end
        req[d][m] = 1'b1;
        if (both) begin
            we[d][o] = 1'($urandom);
            if (o == 0) begin addr0[d] = $urandom; wdata0[d] = $urandom; end
            else        begin addr1[d] = $urandom; wdata1[d] = $urandom; end
            req[d][o] = 1'b1;
        end
        n_cyc  = wr ? 1 : L + 2;
        exp_rd = wr ? last_rd[d] : slave_fn(a);
        for (int c = 1; c <= n_cyc; c++) begin
            @(posedge clk); #1;
            chk("ack", 32'(ack[d]), (c == n_cyc) ? 32'(onehot(m)) : 32'd0);
            chk("busy", 32'(busy[d]), (c < n_cyc || wr) ? 32'd1 : 32'd0);
            if (c < n_cyc || wr) begin
                chk("bus_addr",  bus_addr[d],  a);
                chk("bus_wdata", bus_wdata[d], wd);
                chk("bus_we",    32'(bus_we[d]), (wr && c == 1) ? 32'd1 : 32'd0);
                chk("owner",     32'(owner[d]),  32'(m));
            end
            if (c == 1 && both) req[d][o] = 1'b0;
            if (c == 1 && drop) req[d][m] = 1'b0;
            if (c == n_cyc) begin
                chk("rdata", rdata[d], exp_rd);
                req[d][m] = 1'b0;
            end
        end
        last_served[d] = m;
        last_rd[d]     = exp_rd;
        @(posedge clk); #1;
        chk_idle(d, "post");
        chk("post owner", 32'(owner[d]), 32'(m));
        $display("txn dut=%0d m=%0d %s addr=%h wdata=%h rdata=%h both=%0d drop=%0d",
                 d, m, wr ? "WR" : "RD", a, wd, rdata[d], both, drop);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 2'b00; we[d] = 2'b00;
            addr0[d] = '0; addr1[d] = '0; wdata0[d] = '0; wdata1[d] = '0;
            last_served[d] = 1; last_rd[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_idle(d, "reset");
            chk("reset rdata", rdata[d], 32'd0);
            chk("reset owner", 32'(owner[d]), 32'd0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Contention from reset, both masters holding write requests.
        begin
            int w;
            w = 1 - last_served[0];
            we[0] = 2'b11; addr0[0] = 32'h100; addr1[0] = 32'h200;
            wdata0[0] = 32'h11; wdata1[0] = 32'h22;
            req[0] = 2'b11;
            for (int c = 1; c <= 8; c++) begin
                @(posedge clk); #1;
                chk("contend ack", 32'(ack[0]), (c % 2 == 1) ? 32'(onehot(w)) : 32'd0);
                if (c % 2 == 1) begin
                    $display("txn dut=0 contend ack=%b", ack[0]);
                    last_served[0] = w;
                    w = 1 - w;
                end
                if (c == 8) req[0] = 2'b00;
            end
            @(posedge clk); #1;
            chk_idle(0, "contend end");
        end

        // Directed cases
        do_txn(0, 0, 0, 1, 32'h0000_2004, 32'h0000_00A5, 0);
        do_txn(0, 1, 0, 0, 32'h0000_1000, 32'h0, 0);
        do_txn(0, 0, 0, 0, 32'h0000_2000, 32'h0, 0);
        do_txn(0, 0, 0, 1, 32'h0000_2008, 32'h1234_5678, 0);
        do_txn(0, 0, 0, 0, 32'h0000_4444, 32'h0, 1);
        do_txn(1, 0, 0, 0, 32'h0000_5550, 32'h0, 1);
        do_txn(1, 1, 0, 0, 32'h0000_1000, 32'h0, 0);

        // Reset in the middle of a read on the READ_LAT = 3 instance
        we[1][0] = 1'b0; addr0[1] = 32'h0000_3000; req[1][0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrd busy", 32'(busy[1]), 32'd1);
        rst_n[1] = 1'b0;
        req[1]   = 2'b00;
        #1;
        chk_idle(1, "midrd rst");
        chk("midrd rdata", rdata[1], 32'd0);
        chk("midrd owner", 32'(owner[1]), 32'd0);
        last_served[1] = 1; last_rd[1] = '0;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("midrd noack", 32'(ack[1]), 32'd0);
        end
        $display("txn dut=1 reset during read, aborted");
        do_txn(1, 1, 0, 0, 32'h0000_2000, 32'h0, 0);

        // Randomised transactions on both instances
        for (int i = 0; i < 80; i++) begin
            int d;
            d = i % 2;
            do_txn(d, int'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
                   1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
